// File: rtl/irq_pkg.sv
// irq_pkg: shared definitions for the interrupt priority controller.
//   - default geometry (request count, vector base/stride, address width)
//   - FSM state type for the offer handshake
//   - top_index: priority encoder returning the highest set bit index
package irq_pkg;

  localparam int DEFAULT_N_IRQ      = 3;
  localparam int DEFAULT_ADDR_WIDTH = 16;
  localparam logic [15:0] DEFAULT_VEC_BASE   = 16'h0100;
  localparam logic [15:0] DEFAULT_VEC_STRIDE = 16'h0040;

  // The encoder works on a fixed-width vector so one function serves any
  // N_IRQ up to MAX_IRQ; callers zero-extend their narrower vectors.
  localparam int MAX_IRQ = 32;
  localparam int IDX_W   = 5;

  typedef enum logic {
    IDLE,
    OFFER
  } irq_state_t;

  // Returns 0 for an all-zero vector; callers that care test for zero first.
  function automatic logic [IDX_W-1:0] top_index(input logic [MAX_IRQ-1:0] v);
    top_index = '0;
    for (int i = 0; i < MAX_IRQ; i++) begin
      if (v[i]) top_index = IDX_W'(i);
    end
  endfunction

endpackage

// File: rtl/irq_edge_sync.sv
// irq_edge_sync: one request line through a 2-flop synchroniser, then a
// rising-edge detector against a third flop.
//   clk   in  : CPU clock
//   rst   in  : synchronous active-high reset
//   d_in  in  : raw asynchronous request line
//   rise  out : one-cycle pulse per synchronised rising edge
module irq_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  output logic rise
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;

  // Shift the raw line down the synchroniser chain; prev holds the last
  // synchronised value so a held level yields only one pulse.
  always_comb begin
    sync1_d = d_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  // Register the chain; reset clears every stage so no edge is seen
  // until the line is observed low-then-high after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign rise = sync2_q & ~prev_q;

endmodule

// File: rtl/irq_priority_ctrl.sv
// irq_priority_ctrl: vectored, nesting fixed-priority interrupt controller.
// Edge-detected requests are latched in pending, arbitrated against the
// in-service set and offered one at a time over an int_req/int_ack handshake.
//   clk      in  : CPU clock
//   rst      in  : synchronous active-high reset
//   irq_in   in  : raw request lines, line N_IRQ-1 highest priority
//   ie       in  : global interrupt enable
//   int_ack  in  : pipeline accepted the offered interrupt (pulse)
//   eret     in  : current handler returned (pulse)
//   int_req  out : interrupt offered
//   int_vec  out : handler address, valid while int_req
//   irw      out : in-service vector (lamps)
//   pending  out : latched, unacknowledged requests
module irq_priority_ctrl
  import irq_pkg::*;
#(
  parameter int N_IRQ      = DEFAULT_N_IRQ,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] VEC_BASE   = ADDR_WIDTH'(DEFAULT_VEC_BASE),
  parameter logic [ADDR_WIDTH-1:0] VEC_STRIDE = ADDR_WIDTH'(DEFAULT_VEC_STRIDE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_IRQ-1:0]      irq_in,
  input  logic                  ie,
  input  logic                  int_ack,
  input  logic                  eret,
  output logic                  int_req,
  output logic [ADDR_WIDTH-1:0] int_vec,
  output logic [N_IRQ-1:0]      irw,
  output logic [N_IRQ-1:0]      pending
);

  irq_state_t            state_q, state_d;
  logic [IDX_W-1:0]      sel_q, sel_d;
  logic [ADDR_WIDTH-1:0] int_vec_q, int_vec_d;
  logic                  int_req_q, int_req_d;
  logic [N_IRQ-1:0]      pending_q, pending_d;
  logic [N_IRQ-1:0]      isr_q, isr_d;

  logic [N_IRQ-1:0] rise;
  logic [IDX_W-1:0] pend_top;
  logic [IDX_W-1:0] isr_top;
  logic             eligible;
  logic [N_IRQ-1:0] sel_mask;
  logic [N_IRQ-1:0] pend_clr;
  logic [N_IRQ-1:0] isr_set;
  logic [N_IRQ-1:0] isr_clr;

  for (genvar g = 0; g < N_IRQ; g++) begin : g_sync
    irq_edge_sync u_sync (
      .clk  (clk),
      .rst  (rst),
      .d_in (irq_in[g]),
      .rise (rise[g])
    );
  end

  assign pend_top = top_index(MAX_IRQ'(pending_q));
  assign isr_top  = top_index(MAX_IRQ'(isr_q));
  assign sel_mask = N_IRQ'(1) << sel_q;

  // Only a strictly higher level may preempt; an empty in-service set
  // admits any pending line.
  assign eligible = (pending_q != '0) && ie &&
                    ((isr_q == '0) || (pend_top > isr_top));

  // Next-state logic. Once an offer is made, sel and int_vec stay frozen
  // until ack or withdrawal, so a late higher request waits for IDLE.
  // Ack is checked before ie so an ack in the cycle ie drops still wins.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    int_vec_d = int_vec_q;
    int_req_d = int_req_q;
    pend_clr  = '0;
    isr_set   = '0;

    case (state_q)
      IDLE: begin
        if (eligible) begin
          state_d   = OFFER;
          sel_d     = pend_top;
          int_vec_d = VEC_BASE + ADDR_WIDTH'(pend_top) * VEC_STRIDE;
          int_req_d = 1'b1;
        end
      end
      OFFER: begin
        if (int_ack) begin
          state_d   = IDLE;
          int_req_d = 1'b0;
          pend_clr  = sel_mask;
          isr_set   = sel_mask;
        end else if (!ie) begin
          state_d   = IDLE;
          int_req_d = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        int_req_d = 1'b0;
      end
    endcase

    isr_clr = ((eret) && (isr_q != '0)) ? (N_IRQ'(1) << isr_top) : '0;

    // A new edge is OR-ed in after the ack clear, so the set wins.
    pending_d = (pending_q & ~pend_clr) | rise;
    isr_d     = (isr_q & ~isr_clr) | isr_set;
  end

  // Single state register for the FSM and its registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      int_vec_q <= '0;
      int_req_q <= 1'b0;
      pending_q <= '0;
      isr_q     <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      int_vec_q <= int_vec_d;
      int_req_q <= int_req_d;
      pending_q <= pending_d;
      isr_q     <= isr_d;
    end
  end

  assign int_req = int_req_q;
  assign int_vec = int_vec_q;
  assign irw     = isr_q;
  assign pending = pending_q;

endmodule

// File: doc/irq_priority_ctrl.md
# irq_priority_ctrl

Vectored, nesting-capable interrupt controller between the board request buttons and the pipelined CPU. Synchronises and edge-detects `N_IRQ` raw request lines, latches them as pending, and arbitrates by fixed priority against the in-service set. It offers one request at a time to the pipeline over a req/ack handshake and retires in-service levels on handler return. The in-service vector drives the `IRW` lamps directly.

## Interface
- `N_IRQ`, 3: number of request lines; line `N_IRQ-1` has the highest priority.
- `ADDR_WIDTH`, 16: width of the handler vector (instruction address).
- `VEC_BASE`, 16'h0100: handler address for line 0.
- `VEC_STRIDE`, 16'h0040: address distance between consecutive line handlers.

- `clk`  in  1: CPU clock; single clock domain.
- `rst`  in  1: synchronous, active-high reset.
- `irq_in`  in  N_IRQ: raw asynchronous request lines (buttons), active-high.
- `ie`  in  1: global interrupt enable from the CPU status register.
- `int_ack`  in  1: one-cycle pulse; the pipeline has taken the offered interrupt.
- `eret`  in  1: one-cycle pulse; the current handler has returned.
- `int_req`  out  1: interrupt offered to the pipeline.
- `int_vec`  out  ADDR_WIDTH: handler address; valid while `int_req`=1.
- `irw`  out  N_IRQ: in-service vector (lamp per level).
- `pending`  out  N_IRQ: latched, not-yet-acknowledged requests.

## Operation
- Per line: 2-flop synchroniser, then a rising-edge detect against a third flop. An edge sets `pending[i]`. Level-held lines produce one request only.
- `top(v)` is the index of the highest set bit in `v`. "Eligible" means `pending` is nonzero, `ie`=1, and `top(pending)` > `top(isr)` (or `isr`=0).
- FSM states:
  - IDLE: when eligible, latch `sel`=`top(pending)` and `int_vec`=`VEC_BASE + sel*VEC_STRIDE` (mod 2^ADDR_WIDTH), then go to OFFER.
  - OFFER: `int_req`=1, with `sel` and `int_vec` frozen; no re-arbitration even if a higher line becomes pending.
    - On `int_ack`: `pending[sel]` cleared, `isr[sel]` set, go to IDLE.
    - Else if `ie`=0: withdraw to IDLE with `pending` unchanged.
- `eret`: clear bit `top(isr)`. Ignored if `isr`=0.
- Outputs: `irw`=`isr`; `pending` is the register itself.
- Boundary rules:
  - An edge on a line already pending is merged, i.e. lost.
  - An edge on a line in service sets pending. It is served only after that level retires, because equal priority does not preempt.
  - `int_ack` together with a new edge on `sel`: the set wins, so the line stays pending.
  - `int_ack` together with `eret`: `isr_next = (isr & ~onehot(top(isr))) | onehot(sel)`.
  - `int_ack` while `int_req`=0: ignored.
  - `ie` falls in the same cycle as `int_ack`: the ack wins.
  - `rst` mid-handshake: immediate return to IDLE; all state cleared.

## Timing
- Reset values: `int_req`=0, `int_vec`=0, `irw`=0, `pending`=0, FSM=IDLE, all synchroniser and edge flops 0.
- `irq_in` first sampled high at edge 0:
  - `pending[i]`=1 after edge 2.
  - `int_req`=1 after edge 3, with `int_vec` valid in the same cycle.
- `int_ack` sampled at edge k: `int_req`=0 and `irw[sel]`=1 after edge k.
  - Next offer no earlier than after edge k+1.
- `eret` at edge k: `irw` updated after edge k; a newly eligible offer appears after edge k+1.
- `int_req` stays high until ack, withdrawal, or reset; minimum request-to-offer latency is 4 edges.

## Structure
- Package `irq_pkg`:
  - FSM state typedef (IDLE, OFFER).
  - Default `N_IRQ`, `VEC_BASE`, `VEC_STRIDE` constants.
  - `top_index` priority-encode function.
- Sub-module `irq_edge_sync`: per-line 2-flop synchroniser plus rising-edge pulse; instantiated `N_IRQ` times.
- Top holds `pending`, `isr`, FSM and vector arithmetic.

## Test plan
- Raise `irq_in`=3'b001 and hold, `ie`=1 -> `int_req`=1 four edges later with `int_vec`=16'h0100; ack -> `irw`=001, `pending`=000; no second request while held.
- Assert `irq_in[0]` and `irq_in[2]` in the same cycle -> first offer 16'h0180, `irw`=100 after ack; line 0 offered only after `eret`.
- Line 0 in service, then raise line 1 -> nested offer 16'h0140, `irw`=011 after ack; two `eret` pulses -> 001, then 000.
- Line 1 in service, raise line 0 -> `int_req` stays 0 and `pending`=001 until `eret`, then 16'h0100 is offered.
- Drop `ie` during OFFER -> `int_req`=0 next cycle with `pending` kept; restore `ie` -> re-offered. Separately, pulse `int_ack` and `eret` together with `isr`=001 and `sel`=2 -> `irw`=100.
- Assert `rst` while `int_req`=1 and `irw`=010 -> all outputs 0 after that edge; a stray `int_ack` afterwards is ignored.
